// File: rtl/qrng_pkg.sv
// Shared definitions for the QRNG bit collector.
//   BYTE_W          : width of an assembled output byte
//   SAMPLE_DIV_DEF  : default clk cycles between raw samples
//   REP_LIMIT_DEF   : default repetition-count failure threshold
//   debias_state_e  : von Neumann pair state (first / second bit of a pair)
package qrng_pkg;
  localparam int BYTE_W         = 8;
  localparam int SAMPLE_DIV_DEF = 4;
  localparam int REP_LIMIT_DEF  = 16;

  typedef enum logic [0:0] {
    DB_FIRST  = 1'b0,
    DB_SECOND = 1'b1
  } debias_state_e;
endpackage

// File: rtl/qrng_bit_collector_if.sv
// Byte output port of the QRNG bit collector (valid/ready).
//   out_data  : assembled random byte
//   out_valid : out_data holds an unconsumed byte
//   out_ready : consumer takes the byte when out_valid & out_ready
// master = collector side, slave = consumer side.
interface qrng_bit_collector_if;
  import qrng_pkg::*;

  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/qrng_debias.sv
// Von Neumann debiaser.
//   flush     : forces the pair state back to FIRST, dropping a stored bit
//   debias_en : 1 = pair-based debiasing, 0 = pass every raw sample through
//   raw_vld   : raw sample pulse, raw_bit : sampled value
//   acc_vld   : accepted-bit pulse, acc_bit : accepted value
module qrng_debias
  import qrng_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic debias_en,
  input  logic raw_vld,
  input  logic raw_bit,
  output logic acc_vld,
  output logic acc_bit
);
  localparam logic [0:0] ST_FIRST  = DB_FIRST;
  localparam logic [0:0] ST_SECOND = DB_SECOND;

  logic [0:0] state_q, state_d;
  logic       stored_q, stored_d;

  always_comb begin
    state_d  = state_q;
    stored_d = stored_q;
    acc_vld  = 1'b0;
    acc_bit  = 1'b0;
    if (flush) begin
      state_d = ST_FIRST;
    end else if (!debias_en) begin
      // Pass-through; also drops a half-collected pair if debias was turned off.
      state_d = ST_FIRST;
      acc_vld = raw_vld;
      acc_bit = raw_bit;
    end else if (raw_vld) begin
      if (state_q == ST_FIRST) begin
        stored_d = raw_bit;
        state_d  = ST_SECOND;
      end else begin
        // 10 -> 1, 01 -> 0, equal pairs carry no entropy and are discarded.
        acc_vld = (raw_bit != stored_q);
        acc_bit = stored_q;
        state_d = ST_FIRST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FIRST;
      stored_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stored_q <= stored_d;
    end
  end
endmodule

// File: rtl/qrng_bit_collector.sv
// QRNG bit collector: synchronizes a 1-bit random source, samples it every
// SAMPLE_DIV cycles, runs a repetition-count health test on raw samples,
// optionally von Neumann debiases, packs accepted bits MSB-first into bytes
// and presents them on a valid/ready port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : enable sampling and assembly
//   rnd_bit     : asynchronous random bit input
//   debias_en   : 1 = von Neumann debiasing
//   clear_flags : pulse, clears health_fail / overrun and the repetition count
//   bus         : byte output port (master side)
//   health_fail : sticky repetition-count failure
//   overrun     : sticky, a completed byte was dropped under backpressure
module qrng_bit_collector
  import qrng_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  rnd_bit,
  input  logic                  debias_en,
  input  logic                  clear_flags,
  qrng_bit_collector_if.master  bus,
  output logic                  health_fail,
  output logic                  overrun
);
  localparam int              DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int              CNT_W    = $clog2(BYTE_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [7:0]      REP_MAX  = 8'(REP_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W - 1);

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              prev_q, prev_d;
  logic [7:0]        rep_q, rep_d;
  logic              health_q, health_d;
  logic              ovr_q, ovr_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  logic sample, new_fail, blocked, flush, raw_vld;
  logic acc_vld, acc_bit, complete, hs, ovr_new;

  qrng_debias u_debias (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .debias_en (debias_en),
    .raw_vld   (raw_vld),
    .raw_bit   (sync2_q),
    .acc_vld   (acc_vld),
    .acc_bit   (acc_bit)
  );

  always_comb begin
    sync1_d = rnd_bit;
    sync2_d = sync1_q;

    sample = en && (div_q == DIV_LAST);
    if (!en || sample) div_d = '0;
    else               div_d = div_q + 1'b1;

    // Health test on raw samples; rep_q == 0 marks "no previous sample".
    rep_d    = rep_q;
    prev_d   = prev_q;
    new_fail = 1'b0;
    if (sample) begin
      prev_d = sync2_q;
      if (rep_q == 8'd0 || sync2_q != prev_q) rep_d = 8'd1;
      else if (rep_q != REP_MAX)              rep_d = rep_q + 8'd1;
      new_fail = (rep_d == REP_MAX);
    end else if (clear_flags) begin
      rep_d = 8'd0;
    end
    // A failure raised in the same cycle as clear_flags takes priority.
    health_d = new_fail | (health_q & ~clear_flags);

    // The failing sample itself is already rejected.
    blocked = health_q | new_fail;
    flush   = ~en | blocked;
    raw_vld = sample & ~blocked;

    shreg_d  = shreg_q;
    bcnt_d   = bcnt_q;
    complete = 1'b0;
    if (flush) begin
      bcnt_d = '0;
    end else if (acc_vld) begin
      shreg_d  = {shreg_q[BYTE_W-2:0], acc_bit};
      complete = (bcnt_q == CNT_LAST);
      bcnt_d   = complete ? '0 : bcnt_q + 1'b1;
    end

    // A same-cycle handshake frees the slot for the byte completing now.
    hs      = valid_q & bus.out_ready;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_new = 1'b0;
    if (complete) begin
      if (!valid_q || hs) begin
        data_d  = shreg_d;
        valid_d = 1'b1;
      end else begin
        ovr_new = 1'b1;
      end
    end else if (hs) begin
      valid_d = 1'b0;
    end
    ovr_d = ovr_new | (ovr_q & ~clear_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      div_q    <= '0;
      prev_q   <= 1'b0;
      rep_q    <= 8'd0;
      health_q <= 1'b0;
      ovr_q    <= 1'b0;
      shreg_q  <= '0;
      bcnt_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      div_q    <= div_d;
      prev_q   <= prev_d;
      rep_q    <= rep_d;
      health_q <= health_d;
      ovr_q    <= ovr_d;
      shreg_q  <= shreg_d;
      bcnt_q   <= bcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign health_fail   = health_q;
  assign overrun       = ovr_q;
endmodule

// File: tb/tb_qrng_bit_collector.sv
module tb_qrng_bit_collector;
  import qrng_pkg::*;

  localparam int SDIV = 4;
  localparam int RLIM = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic rnd_bit = 1'b0;
  logic debias_en = 1'b0;
  logic clear_flags = 1'b0;
  logic health_fail, overrun;

  qrng_bit_collector_if bus();

  qrng_bit_collector #(.SAMPLE_DIV(SDIV), .REP_LIMIT(RLIM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rnd_bit     (rnd_bit),
    .debias_en   (debias_en),
    .clear_flags (clear_flags),
    .bus         (bus),
    .health_fail (health_fail),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Reference model state
  int         m_rep = 0;
  bit         m_prev = 0;
  bit         m_fail = 0;
  bit         m_have = 0;
  bit         m_stored = 0;
  int         m_cnt = 0;
  int         m_acc = 0;
  logic [7:0] m_bytes[$];
  bit         st[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_accept(bit b);
    m_acc = (m_acc * 2 + int'(b)) % 256;
    m_cnt++;
    if (m_cnt == 8) begin
      m_bytes.push_back(8'(m_acc));
      m_cnt = 0;
    end
  endfunction

  function automatic void model_sample(bit b, bit deb);
    bit nf = 0;
    if (m_rep == 0 || b != m_prev) m_rep = 1;
    else if (m_rep < RLIM)         m_rep++;
    m_prev = b;
    if (m_rep == RLIM) nf = 1;
    if (m_fail || nf) begin
      m_fail = 1;
      m_have = 0;
      m_cnt  = 0;
      return;
    end
    if (!deb) model_accept(b);
    else if (!m_have) begin
      m_stored = b;
      m_have   = 1;
    end else begin
      m_have = 0;
      if (b != m_stored) model_accept(m_stored);
    end
  endfunction

  function automatic void st_byte(logic [7:0] v);
    for (int i = 7; i >= 0; i--) st.push_back(v[i]);
  endfunction

  // Drives st[] one bit per sample period, starting with the prescaler at 0.
  task automatic drive(input bit deb, input int push_max = -1, input bit keep_en = 0,
                       input bit rnd_rdy = 0, input bit rdy_last = 0);
    debias_en = deb;
    m_have = 0;
    m_cnt  = 0;
    m_bytes.delete();
    foreach (st[i]) model_sample(st[i], deb);
    for (int i = 0; i < m_bytes.size(); i++)
      if (push_max < 0 || i < push_max) exp_q.push_back(m_bytes[i]);
    en = 1'b1;
    for (int i = 0; i < st.size(); i++) begin
      rnd_bit = st[i];
      for (int c = 0; c < SDIV; c++) begin
        if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        if (rdy_last && i == st.size() - 1 && c == SDIV - 1) bus.out_ready = 1'b1;
        @(posedge clk); #1;
      end
    end
    if (rdy_last) bus.out_ready = 1'b0;
    if (!keep_en) begin
      en = 1'b0;
      @(posedge clk); #1;
    end
    st.delete();
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    m_fail = 0;
    m_rep  = 0;
  endtask

  task automatic consume(input string name);
    int n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    bus.out_ready = 1'b0;
    check(name, {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus.out_ready = 1'b0;
    check(name, exp_q.size(), 32'd0);
  endtask

  // Scoreboard monitor: every handshake must deliver the next expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", bus.out_data, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("sb_byte", {24'd0, bus.out_data}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",   {24'd0, bus.out_data}, 32'h00);
    check("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
    check("rst_health", {31'd0, health_fail}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain packing
    st_byte(8'hB2);
    drive(1'b0);
    check("t1_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t1_data", {24'd0, bus.out_data}, 32'hB2);
    check("t1_health", {31'd0, health_fail}, 32'd0);
    check("t1_overrun", {31'd0, overrun}, 32'd0);
    consume("t1_consume");

    // Debiased pairs
    st = '{1,0, 0,1, 1,1, 1,0, 1,0, 0,0, 0,1, 0,1, 1,0, 0,1};
    drive(1'b1);
    check("t2_data", {24'd0, bus.out_data}, 32'hB2);
    check("t2_valid", {31'd0, bus.out_valid}, 32'd1);
    consume("t2_consume");

    // Backpressure overrun
    st_byte(8'hB2);
    st_byte(8'h4D);
    drive(1'b0, 1);
    check("t3_data", {24'd0, bus.out_data}, 32'hB2);
    check("t3_overrun", {31'd0, overrun}, 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("t3_valid_clr", {31'd0, bus.out_valid}, 32'd0);
    check("t3_overrun_sticky", {31'd0, overrun}, 32'd1);
    pulse_clear();
    check("t3_overrun_clr", {31'd0, overrun}, 32'd0);

    // Repetition-count failure
    for (int i = 0; i < 15; i++) st.push_back(1'b1);
    drive(1'b1);
    check("t4_health_15", {31'd0, health_fail}, {31'd0, m_fail});
    check("t4_health_15_lo", {31'd0, health_fail}, 32'd0);
    st.push_back(1'b1);
    drive(1'b1);
    check("t4_health_16", {31'd0, health_fail}, 32'd1);
    check("t4_no_byte", {31'd0, bus.out_valid}, 32'd0);
    pulse_clear();
    check("t4_health_clr", {31'd0, health_fail}, 32'd0);
    st_byte(8'hAA);
    drive(1'b0);
    check("t4_data", {24'd0, bus.out_data}, 32'hAA);
    consume("t4_consume");

    // Handshake coincides with completion
    st_byte(8'hB2);
    drive(1'b0);
    st_byte(8'h4D);
    drive(1'b0, -1, 0, 0, 1);
    check("t5_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t5_data", {24'd0, bus.out_data}, 32'h4D);
    check("t5_overrun", {31'd0, overrun}, 32'd0);

    // Asynchronous reset mid-byte, with 0x4D still pending
    st = '{1,1,0,1,0};
    drive(1'b0, -1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t6_data", {24'd0, bus.out_data}, 32'h00);
    check("t6_health", {31'd0, health_fail}, 32'd0);
    check("t6_overrun", {31'd0, overrun}, 32'd0);
    exp_q.delete();
    m_rep = 0; m_fail = 0; m_prev = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    st_byte(8'h3C);
    drive(1'b0);
    check("t6_data_after", {24'd0, bus.out_data}, 32'h3C);
    consume("t6_consume");

    // Randomized blocks with random consumer readiness
    for (int b = 0; b < 8; b++) begin
      bit deb;
      int n;
      deb = 1'($urandom_range(0, 1));
      n = 16 + int'($urandom_range(0, 40));
      for (int i = 0; i < n; i++) st.push_back(1'($urandom_range(0, 1)));
      drive(deb, -1, 0, 1);
      drain("rnd_drain");
      check("rnd_health", {31'd0, health_fail}, {31'd0, m_fail});
      check("rnd_overrun", {31'd0, overrun}, 32'd0);
      if (m_fail) pulse_clear();
    end

    check("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qrng_bit_collector.md
Name: qrng_bit_collector

Overview:
Consumer end of the quantum random-bit stream. It samples a 1-bit random source (possibly asynchronous) and optionally applies von Neumann debiasing. It runs a repetition-count health test, packs accepted bits MSB-first into bytes, and presents each byte on a valid/ready output port. It sits between the random-bit generator output pin and any downstream byte consumer (SPI/UART readout, on-chip logic).

Parameters:
SAMPLE_DIV, 4, clk cycles between raw samples (>=1)
REP_LIMIT, 16, consecutive identical raw samples that trigger health failure (2..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  enable sampling/assembly
rnd_bit  in  1  random bit stream, treated as asynchronous
debias_en  in  1  1 = von Neumann debiasing on
clear_flags  in  1  single-cycle pulse, clears sticky flags
out_data  out  8  assembled random byte
out_valid  out  1  out_data holds an unconsumed byte
out_ready  in  1  consumer accepts the byte when out_valid & out_ready
health_fail  out  1  sticky repetition-count failure
overrun  out  1  sticky: completed byte dropped due to backpressure

Behaviour:
- Reset: out_data=0x00, out_valid=0, health_fail=0, overrun=0. Synchronizer, prescaler, debias state, shift register, bit count and repetition count all cleared. Reset asserted mid-byte discards the partial byte.
- rnd_bit passes through a 2-flop synchronizer, giving 2 cycles of latency.
- Prescaler: counts 0..SAMPLE_DIV-1 while en=1 and issues a sample pulse when it wraps. With en=0 the prescaler is held at 0, debias state returns to FIRST, and bit count goes to 0. The output handshake and flags are unaffected by en.
- Health test runs on raw samples, before debiasing:
  - rep_cnt=1 on the first sample, or on any sample that differs from the previous one.
  - Otherwise rep_cnt increments, saturating at REP_LIMIT.
  - When rep_cnt reaches REP_LIMIT, health_fail=1 and stays set until clear_flags.
- While health_fail=1: no bits are accepted and bit count is held at 0. A byte already in out_data stays deliverable.
- Debias FSM, states FIRST and SECOND:
  - debias_en=0: every raw sample is an accepted bit and the FSM stays in FIRST.
  - debias_en=1, FIRST: store the sample, go to SECOND.
  - debias_en=1, SECOND: if sample != stored bit, accept the stored bit (pair 10 -> 1, pair 01 -> 0); if equal, discard the pair. Return to FIRST in both cases.
  - debias_en deasserted while in SECOND: drop the stored bit, go to FIRST.
- Assembly: shreg <= {shreg[6:0], bit} on each accepted bit. The 8th bit completes the byte and bit count wraps to 0.
- Output, on a completed byte:
  - If out_valid=0, or out_valid&out_ready in the same cycle: load out_data, out_valid=1.
  - Otherwise: drop the new byte, overrun=1, out_data unchanged.
  - out_valid clears on out_valid&out_ready when no byte completes in that cycle.
- clear_flags: health_fail=0, overrun=0, rep_cnt=0. It does not affect out_data or out_valid.
- If clear_flags and a new failure coincide in the same cycle, the failure wins.

Decomposition:
- Package qrng_pkg: BYTE_W=8, default SAMPLE_DIV and REP_LIMIT constants, typedef for the debias state enum {FIRST, SECOND}.
- Sub-module qrng_debias: raw sample pulse/bit in, accepted-bit pulse/bit out, with FSM and drop-on-disable. Everything else is in the top.

Test Plan:
1. debias_en=0, SAMPLE_DIV=4; rnd_bit sequence 1,0,1,1,0,0,1,0, each bit held 4 cycles and aligned to sample pulses -> out_data=0xB2, out_valid=1 one cycle after the 8th sample pulse, no flags set.
2. debias_en=1; raw pairs 10,01,11,10,10,00,01,01,10,01 -> pairs 11 and 00 discarded, out_data=0xB2 after the 10th pair.
3. out_ready=0; stream 16 bits (0xB2 then 0x4D) -> out_data stays 0xB2, overrun=1. Then out_ready=1 for one cycle -> out_valid=0. Then clear_flags -> overrun=0.
4. rnd_bit held 1 for 16 samples, REP_LIMIT=16 -> health_fail=1 on the 16th sample pulse and no byte produced. Then clear_flags plus alternating stream -> next byte assembled normally.
5. Backpressure boundary: out_valid=1 and out_ready=1 in the same cycle that byte 0x4D completes -> out_valid stays 1, out_data=0x4D, overrun=0.
6. rst_n pulsed low asynchronously after 5 accepted bits -> all outputs 0 immediately. The next byte is formed from 8 fresh bits only, with no residue from the partial byte.
